// File: rtl/brisc_pkg.sv
// rtl/brisc_pkg.sv - shared core-wide width parameters
package brisc_pkg;
    localparam int XLEN = 32;
endpackage

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - committed-store FIFO with dcache drain and load forwarding
// Optional macro STB_FWD_EN compiles in store-to-load data forwarding.
module store_buffer
    import brisc_pkg::*;
#(
    parameter int NUM_ENTRIES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            st_valid_in,
    input  logic [XLEN-1:0] st_addr_in,
    input  logic [XLEN-1:0] st_data_in,
    input  logic            st_byte_in,
    output logic            full_out,
    input  logic            flush_in,
    input  logic            kill_in,
    output logic            dc_req_out,
    output logic [XLEN-1:0] dc_addr_out,
    output logic [XLEN-1:0] dc_data_out,
    output logic            dc_byte_out,
    input  logic            dc_ready_in,
    input  logic [XLEN-1:0] ld_addr_in,
    input  logic            ld_byte_in,
    output logic            ld_hit_out,
    output logic [XLEN-1:0] ld_data_out,
    output logic            ld_stall_out
);
    localparam int PW = $clog2(NUM_ENTRIES);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t                state, state_next;
    logic [NUM_ENTRIES-1:0] e_valid, e_cmt, e_byte;
    logic [XLEN-1:0]       e_addr [NUM_ENTRIES];
    logic [XLEN-1:0]       e_data [NUM_ENTRIES];
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         count;

    logic                  push, pop;
    logic                  flush_found, flush_do;
    logic [PW-1:0]         flush_idx, scan_idx;
    logic [CW-1:0]         n_cmt;
    logic                  m_found;
    logic [PW-1:0]         m_idx, fwd_idx;

    assign full_out   = (count == CW'(NUM_ENTRIES));
    assign dc_req_out = (state == REQ);
    assign pop        = dc_req_out & dc_ready_in;
    assign push       = st_valid_in & ~full_out & ~kill_in;
    assign flush_do   = flush_in & flush_found;

    assign dc_addr_out = dc_req_out ? e_addr[head] : '0;
    assign dc_data_out = dc_req_out ? e_data[head] : '0;
    assign dc_byte_out = dc_req_out & e_byte[head];

    // Committed entries always form a contiguous run starting at head, so the
    // first uncommitted valid entry seen from head is the flush target.
    always_comb begin
        flush_found = 1'b0;
        flush_idx   = head;
        scan_idx    = head;
        n_cmt       = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            scan_idx = head + PW'(k);
            if (e_valid[scan_idx] && e_cmt[scan_idx]) begin
                n_cmt = n_cmt + CW'(1);
            end else if (e_valid[scan_idx] && !flush_found) begin
                flush_found = 1'b1;
                flush_idx   = scan_idx;
            end
        end
        if (flush_do) begin
            n_cmt = n_cmt + CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (e_valid[head] && (e_cmt[head] || (flush_do && flush_idx == head)))
                      state_next = REQ;
            REQ:  if (dc_ready_in)
                      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            e_valid <= '0;
            e_cmt   <= '0;
            e_byte  <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                e_addr[k] <= '0;
                e_data[k] <= '0;
            end
        end else begin
            state <= state_next;
            if (pop) begin
                e_valid[head] <= 1'b0;
                e_cmt[head]   <= 1'b0;
                head          <= head + PW'(1);
            end
            if (flush_do) begin
                e_cmt[flush_idx] <= 1'b1;
            end
            if (kill_in) begin
                // The entry committed by a same-cycle flush survives the kill.
                for (int k = 0; k < NUM_ENTRIES; k++) begin
                    if (!e_cmt[k] && !(flush_do && flush_idx == PW'(k)))
                        e_valid[k] <= 1'b0;
                end
                tail  <= head + n_cmt[PW-1:0];
                count <= n_cmt - CW'(pop);
            end else begin
                if (push) begin
                    e_valid[tail] <= 1'b1;
                    e_cmt[tail]   <= 1'b0;
                    e_addr[tail]  <= st_addr_in;
                    e_data[tail]  <= st_data_in;
                    e_byte[tail]  <= st_byte_in;
                    tail          <= tail + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Scan oldest to youngest so the youngest word-address match wins.
    always_comb begin
        m_found = 1'b0;
        m_idx   = head;
        fwd_idx = head;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            fwd_idx = head + PW'(k);
            if (e_valid[fwd_idx] && e_addr[fwd_idx][XLEN-1:2] == ld_addr_in[XLEN-1:2]) begin
                m_found = 1'b1;
                m_idx   = fwd_idx;
            end
        end
    end

`ifdef STB_FWD_EN
    logic [XLEN-1:0] m_data;
    assign m_data = e_data[m_idx];

    always_comb begin
        ld_hit_out   = 1'b0;
        ld_stall_out = 1'b0;
        ld_data_out  = '0;
        if (m_found) begin
            if (!e_byte[m_idx]) begin
                ld_hit_out  = 1'b1;
                ld_data_out = ld_byte_in ? {{(XLEN-8){1'b0}}, m_data[{ld_addr_in[1:0], 3'b000} +: 8]}
                                         : m_data;
            end else if (ld_byte_in && e_addr[m_idx] == ld_addr_in) begin
                ld_hit_out  = 1'b1;
                ld_data_out = {{(XLEN-8){1'b0}}, m_data[7:0]};
            end else begin
                ld_stall_out = 1'b1;
            end
        end
    end
`else
    logic unused_ld;
    assign unused_ld    = ^{ld_byte_in, ld_addr_in[1:0], m_idx};
    assign ld_hit_out   = 1'b0;
    assign ld_data_out  = '0;
    assign ld_stall_out = m_found;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - table-driven self-checking bench for store_buffer
module tb_store_buffer;
    import brisc_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            st_valid_in, st_byte_in, flush_in, kill_in, dc_ready_in, ld_byte_in;
    logic [XLEN-1:0] st_addr_in, st_data_in, ld_addr_in;
    logic            full_out, dc_req_out, dc_byte_out, ld_hit_out, ld_stall_out;
    logic [XLEN-1:0] dc_addr_out, dc_data_out, ld_data_out;

    store_buffer #(.NUM_ENTRIES(4)) dut (
        .clk(clk), .reset(reset),
        .st_valid_in(st_valid_in), .st_addr_in(st_addr_in), .st_data_in(st_data_in),
        .st_byte_in(st_byte_in), .full_out(full_out), .flush_in(flush_in), .kill_in(kill_in),
        .dc_req_out(dc_req_out), .dc_addr_out(dc_addr_out), .dc_data_out(dc_data_out),
        .dc_byte_out(dc_byte_out), .dc_ready_in(dc_ready_in), .ld_addr_in(ld_addr_in),
        .ld_byte_in(ld_byte_in), .ld_hit_out(ld_hit_out), .ld_data_out(ld_data_out),
        .ld_stall_out(ld_stall_out)
    );

    always #5 clk = ~clk;

    // kind: 0 = no match, 1 = forwardable match (data eld), 2 = match that must stall
    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        sb;
        logic        fl;
        logic        kl;
        logic        rdy;
        logic [31:0] la;
        logic        lb;
        logic        ef;
        logic        er;
        logic [31:0] ea;
        logic [31:0] ed;
        logic        eb;
        int          kind;
        logic [31:0] eld;
    } vec_t;

    vec_t vq[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t v(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                               input logic sb, input logic fl, input logic kl, input logic rdy,
                               input logic [31:0] la, input logic lb, input logic ef, input logic er,
                               input logic [31:0] ea, input logic [31:0] ed, input logic eb,
                               input int kind, input logic [31:0] eld);
        vec_t r;
        r.sv = sv; r.sa = sa; r.sd = sd; r.sb = sb; r.fl = fl; r.kl = kl; r.rdy = rdy;
        r.la = la; r.lb = lb; r.ef = ef; r.er = er; r.ea = ea; r.ed = ed; r.eb = eb;
        r.kind = kind; r.eld = eld;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        st_valid_in = 0; st_addr_in = '0; st_data_in = '0; st_byte_in = 0;
        flush_in = 0; kill_in = 0; dc_ready_in = 0; ld_addr_in = '0; ld_byte_in = 0;
    endtask

    task automatic chk_ld(input string tag, input int kind, input logic [31:0] eld);
        logic        ehit, estall;
        logic [31:0] edat;
        ehit = 0; estall = 0; edat = '0;
`ifdef STB_FWD_EN
        if (kind == 1) begin ehit = 1; edat = eld; end
        if (kind == 2) estall = 1;
`else
        if (kind != 0) estall = 1;
        edat = eld & 32'h0;
`endif
        chk({tag, ".hit"}, 32'(ld_hit_out), 32'(ehit));
        chk({tag, ".stall"}, 32'(ld_stall_out), 32'(estall));
        chk({tag, ".ldata"}, ld_data_out, edat);
    endtask

    task automatic apply(input vec_t r, input int i);
        string tag;
        @(negedge clk);
        st_valid_in = r.sv; st_addr_in = r.sa; st_data_in = r.sd; st_byte_in = r.sb;
        flush_in = r.fl; kill_in = r.kl; dc_ready_in = r.rdy; ld_addr_in = r.la; ld_byte_in = r.lb;
        #1;
        tag = $sformatf("r%0d", i);
        chk({tag, ".full"}, 32'(full_out), 32'(r.ef));
        chk({tag, ".req"}, 32'(dc_req_out), 32'(r.er));
        chk({tag, ".daddr"}, dc_addr_out, r.ea);
        chk({tag, ".ddata"}, dc_data_out, r.ed);
        chk({tag, ".dbyte"}, 32'(dc_byte_out), 32'(r.eb));
        chk_ld(tag, r.kind, r.eld);
    endtask

    initial begin
        // single word store, flush, one-cycle drain
        vq.push_back(v(1,'h100,'hDEADBEEF,0, 0,0,0, 'h100,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(0,0,0,0, 1,0,1, 'h100,0, 0,0,0,0,0, 1,'hDEADBEEF));
        vq.push_back(v(0,0,0,0, 0,0,1, 'h100,0, 0,1,'h100,'hDEADBEEF,0, 1,'hDEADBEEF));
        vq.push_back(v(0,0,0,0, 1,0,0, 'h100,0, 0,0,0,0,0, 0,0));
        // fill to full, dropped fifth push, in-order drain
        vq.push_back(v(1,'h10,1,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(1,'h14,2,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(1,'h18,3,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(1,'h1C,4,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(1,'h20,5,0, 0,0,0, 'h20,0, 1,0,0,0,0, 0,0));
        vq.push_back(v(0,0,0,0, 1,0,0, 'h20,0, 1,0,0,0,0, 0,0));
        vq.push_back(v(0,0,0,0, 1,0,1, 'h20,0, 1,1,'h10,1,0, 0,0));
        vq.push_back(v(0,0,0,0, 1,0,1, 'h10,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(0,0,0,0, 1,0,1, 'h18,0, 0,1,'h14,2,0, 1,3));
        vq.push_back(v(0,0,0,0, 0,0,1, 0,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(0,0,0,0, 0,0,1, 0,0, 0,1,'h18,3,0, 0,0));
        vq.push_back(v(0,0,0,0, 0,0,1, 0,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(0,0,0,0, 0,0,1, 0,0, 0,1,'h1C,4,0, 0,0));
        vq.push_back(v(0,0,0,0, 0,0,1, 'h1C,0, 0,0,0,0,0, 0,0));
        // A,B,C then flush once and kill
        vq.push_back(v(1,'h40,'hA,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(1,'h44,'hB,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(1,'h48,'hC,0, 0,0,0, 'h44,0, 0,0,0,0,0, 1,'hB));
        vq.push_back(v(0,0,0,0, 1,0,0, 'h48,0, 0,0,0,0,0, 1,'hC));
        vq.push_back(v(0,0,0,0, 0,1,0, 'h44,0, 0,1,'h40,'hA,0, 1,'hB));
        vq.push_back(v(0,0,0,0, 0,0,0, 'h44,0, 0,1,'h40,'hA,0, 0,0));
        vq.push_back(v(0,0,0,0, 0,0,1, 'h48,0, 0,1,'h40,'hA,0, 0,0));
        vq.push_back(v(0,0,0,0, 0,0,1, 'h40,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(0,0,0,0, 0,0,1, 0,0, 0,0,0,0,0, 0,0));
        // forwarding cases
        vq.push_back(v(1,'h200,'h11223344,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(1,'h300,'hAB,1, 0,0,0, 'h201,1, 0,0,0,0,0, 1,'h33));
        vq.push_back(v(0,0,0,0, 0,0,0, 'h300,0, 0,0,0,0,0, 2,0));
        vq.push_back(v(0,0,0,0, 0,0,0, 'h300,1, 0,0,0,0,0, 1,'hAB));
        vq.push_back(v(0,0,0,0, 0,0,0, 'h302,1, 0,0,0,0,0, 2,0));
        vq.push_back(v(1,'h300,'h55667788,0, 0,0,0, 'h300,0, 0,0,0,0,0, 2,0));
        vq.push_back(v(0,0,0,0, 0,0,0, 'h303,1, 0,0,0,0,0, 1,'h55));
        vq.push_back(v(0,0,0,0, 0,0,0, 'h204,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(0,0,0,0, 0,1,0, 'h200,0, 0,0,0,0,0, 1,'h11223344));
        vq.push_back(v(0,0,0,0, 0,0,0, 'h200,0, 0,0,0,0,0, 0,0));
        // flush and kill together, with a dropped push
        vq.push_back(v(1,'h60,6,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(1,'h64,7,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(1,'h68,8,0, 1,1,0, 'h68,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(0,0,0,0, 0,0,1, 'h68,0, 0,1,'h60,6,0, 0,0));
        vq.push_back(v(0,0,0,0, 0,0,1, 'h64,0, 0,0,0,0,0, 0,0));
        vq.push_back(v(0,0,0,0, 0,0,1, 'h60,0, 0,0,0,0,0, 0,0));

        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        chk("rst.req", 32'(dc_req_out), 0);
        chk("rst.full", 32'(full_out), 0);
        chk("rst.stall", 32'(ld_stall_out), 0);
        chk("rst.hit", 32'(ld_hit_out), 0);
        chk("rst.daddr", dc_addr_out, 0);
        chk("rst.count", 32'(dut.count), 0);
        reset = 0;

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);
        chk("table.count", 32'(dut.count), 0);

        // held request stays stable, then reset abandons it
        @(negedge clk);
        idle_inputs();
        st_valid_in = 1; st_addr_in = 'h501; st_data_in = 'hEE; st_byte_in = 1;
        @(negedge clk);
        idle_inputs();
        flush_in = 1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            idle_inputs();
            ld_addr_in = 'h501;
            if (c == 3) reset = 1;
            #1;
            chk($sformatf("hold%0d.req", c), 32'(dc_req_out), 1);
            chk($sformatf("hold%0d.addr", c), dc_addr_out, 'h501);
            chk($sformatf("hold%0d.data", c), dc_data_out, 'hEE);
            chk($sformatf("hold%0d.byte", c), 32'(dc_byte_out), 1);
        end
        @(negedge clk);
        reset = 0;
        dc_ready_in = 1;
        #1;
        chk("post_rst.req", 32'(dc_req_out), 0);
        chk("post_rst.count", 32'(dut.count), 0);
        chk("post_rst.stall", 32'(ld_stall_out), 0);
        chk("post_rst.full", 32'(full_out), 0);
        repeat (3) @(negedge clk);
        chk("post_rst.idle_req", 32'(dc_req_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
